// File: rtl/seconds_display_ctrl.sv
// seconds_display_ctrl
//   Free-running BCD seconds counter (00-59) that drives two seven-segment
//   digits. It has an Avalon-MM slave for control, preset, display override
//   and a wrap interrupt.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   address[1:0]          register select: 0 CTRL, 1 SECONDS, 2 OVERRIDE, 3 STATUS
//   chipselect, write_n   a write happens when chipselect && !write_n
//   writedata[31:0]       write data
//   readdata[31:0]        combinational read data (zero wait states)
//   seg_ls[6:0]           units digit pattern, bit0=a .. bit6=g (registered)
//   seg_ms[6:0]           tens digit pattern, same order (registered)
//   irq                   level interrupt, WRAP & IRQ_EN
module seconds_display_ctrl #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  seg_ls,
  output logic [6:0]  seg_ms,
  output logic        irq
);

  // Keep at least one prescaler bit so CLK_HZ=1 still elaborates.
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [6:0] SEG_RST = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_SECONDS  = 2'd1;
  localparam logic [1:0] ADDR_OVERRIDE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~pat : pat;
  endfunction

  logic          run_q, run_d;
  logic          ovr_q, ovr_d;
  logic          irq_en_q, irq_en_d;
  logic [2:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [13:0]   ovr_pat_q, ovr_pat_d;
  logic          wrap_q, wrap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    seg_ls_q, seg_ls_d;
  logic [6:0]    seg_ms_q, seg_ms_d;

  logic wr_en;
  logic sec_load;
  logic tick;
  logic unused_wdata;

  assign wr_en = chipselect && !write_n;
  // A preset is accepted only if it is a legal BCD seconds value.
  assign sec_load = wr_en && (address == ADDR_SECONDS) &&
                    (writedata[3:0] <= 4'd9) && (writedata[6:4] <= 3'd5);
  // Qualified by the registered RUN, so a tick still lands in the cycle RUN is cleared.
  assign tick = run_q && (presc_q == PRESC_TC);
  assign unused_wdata = ^writedata[31:14];

  always_comb begin
    run_d     = run_q;
    ovr_d     = ovr_q;
    irq_en_d  = irq_en_q;
    ovr_pat_d = ovr_pat_q;
    tens_d    = tens_q;
    units_d   = units_q;
    wrap_d    = wrap_q;
    presc_d   = presc_q;

    if (wr_en && address == ADDR_CTRL) begin
      run_d    = writedata[0];
      ovr_d    = writedata[1];
      irq_en_d = writedata[2];
    end
    if (wr_en && address == ADDR_OVERRIDE) begin
      ovr_pat_d = writedata[13:0];
    end

    if (sec_load || !run_q || presc_q == PRESC_TC) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (wr_en && address == ADDR_STATUS && writedata[0]) begin
      wrap_d = 1'b0;
    end

    // A preset in the tick cycle swallows the tick, including any wrap it would cause.
    if (sec_load) begin
      tens_d  = writedata[6:4];
      units_d = writedata[3:0];
    end else if (tick) begin
      if (units_q != 4'd9) begin
        units_d = units_q + 4'd1;
      end else begin
        units_d = 4'd0;
        if (tens_q == 3'd5) begin
          tens_d = 3'd0;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q + 3'd1;
        end
      end
    end

    if (ovr_q) begin
      seg_ls_d = ovr_pat_q[6:0];
      seg_ms_d = ovr_pat_q[13:7];
    end else begin
      seg_ls_d = seg_decode(units_q);
      seg_ms_d = seg_decode({1'b0, tens_q});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      ovr_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ovr_pat_q <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      wrap_q    <= 1'b0;
      presc_q   <= '0;
      seg_ls_q  <= SEG_RST;
      seg_ms_q  <= SEG_RST;
    end else begin
      run_q     <= run_d;
      ovr_q     <= ovr_d;
      irq_en_q  <= irq_en_d;
      ovr_pat_q <= ovr_pat_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      wrap_q    <= wrap_d;
      presc_q   <= presc_d;
      seg_ls_q  <= seg_ls_d;
      seg_ms_q  <= seg_ms_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:     readdata = {29'd0, irq_en_q, ovr_q, run_q};
      ADDR_SECONDS:  readdata = {25'd0, tens_q, units_q};
      ADDR_OVERRIDE: readdata = {18'd0, ovr_pat_q};
      ADDR_STATUS:   readdata = {31'd0, wrap_q};
      default:       readdata = 32'd0;
    endcase
  end

  assign seg_ls = seg_ls_q;
  assign seg_ms = seg_ms_q;
  assign irq    = wrap_q & irq_en_q;

endmodule

// File: doc/seconds_display_ctrl.md
Name: seconds_display_ctrl

Overview:
- Autonomous seconds counter and seven-segment sequencer for the NIOS system; counts 00-59 in BCD from a clk-derived 1 Hz tick.
- Drives both seconds digits (least- and most-significant) as seven-segment patterns.
- Avalon-MM slave, zero-wait read, lets the CPU start/stop, preset, override the display and take a wrap interrupt.

Parameters:
- CLK_HZ, 50000000, clk cycles per second; prescaler terminal count is CLK_HZ-1 (bench uses 4).
- SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted (lit segment = 0).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, zero wait states
- seg_ls  out  7  seconds units pattern, bit0=a .. bit6=g
- seg_ms  out  7  seconds tens pattern, same bit order
- irq  out  1  interrupt, level

Behaviour:
- Reset is asynchronous on reset_n low, applied to every register; clk is the only clock.
- Write occurs when chipselect && !write_n. Unused readdata bits read 0.
- Register 0 CTRL: bit0 RUN, bit1 OVR, bit2 IRQ_EN. Reset value 0.
- Register 1 SECONDS: read {25'b0, tens[2:0], units[3:0]}.
  - Write loads tens=writedata[6:4], units=writedata[3:0] only if units<=9 and tens<=5; otherwise ignored.
  - A valid load clears the prescaler. Reset value 00.
- Register 2 OVERRIDE: bits[6:0] ls pattern, bits[13:7] ms pattern, raw (no inversion applied). Reset value 0.
- Register 3 STATUS: bit0 WRAP. Writing 1 to bit0 clears it; writing 0 has no effect.
- Prescaler:
  - Width is clog2(CLK_HZ).
  - Held at 0 while RUN=0.
  - While RUN=1 it increments each clk; at CLK_HZ-1 it returns to 0 and asserts a one-cycle tick.
  - The first tick occurs CLK_HZ cycles after RUN is set.
- Counter on tick:
  - units<9: units+1.
  - units=9: units=0, tens+1.
  - tens=5 and units=9: 00 and WRAP set.
- Simultaneous events:
  - SECONDS write and tick in the same cycle: the write wins, the tick is discarded.
  - WRAP clear and WRAP set in the same cycle: set wins.
  - RUN cleared in the same cycle as a tick: the tick still applies.
- Decode, per digit, active-high: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Bitwise-inverted when SEG_ACTIVE_LOW=1.
- seg outputs are registered and update one clk after a counter or register change.
  - OVR=1: outputs take the OVERRIDE fields directly.
  - OVR=0: outputs take the decoded counter.
  - Reset value is decode(0) on both: 7'h40 when active-low, 7'h3F otherwise.
- irq = WRAP & IRQ_EN, combinational from registers. Reset 0.
- Reset mid-count: counter, prescaler, flags and outputs return to reset values immediately (asynchronous); counting does not resume until RUN is written again.

Test Plan:
- Reset, no writes, SEG_ACTIVE_LOW=1 -> seg_ls=seg_ms=7'h40, readdata=0 on all four addresses, irq=0.
- CLK_HZ=4; write CTRL=1 -> SECONDS reads 01 after exactly 4 clks and 02 after 8; seg_ls=~7'h06 then ~7'h5B, each one clk after the count change.
- Write SECONDS=0x59, CTRL=5, wait 4 clks -> SECONDS=00, STATUS=1, irq=1; write STATUS=1 -> irq=0 next cycle.
- Write SECONDS=0x6A and 0x3B -> both ignored, value unchanged; write 0x37 on the tick cycle -> reads 37, next tick 4 clks later gives 38.
- Write OVERRIDE=0x3FFF with OVR=1 -> seg_ls=seg_ms=7'h7F one clk later while counting continues; clear OVR -> decoded count returns.
- Assert reset_n low mid-count at SECONDS=23 -> outputs immediately 7'h40, CTRL=0; after release no ticks occur until RUN is set.
